// File: rtl/sidebar_pkg.sv
// Shared constants and helpers for the sidebar drawer.
package sidebar_pkg;

  localparam int unsigned MAX_LAYERS = 6;
  localparam int unsigned COLOUR_W   = 3;
  localparam int unsigned STACK_W    = MAX_LAYERS * COLOUR_W;
  localparam int unsigned COUNT_W    = 3;

  localparam logic [7:0]  DEF_X0      = 8'd140;
  localparam logic [6:0]  DEF_Y_BASE  = 7'd110;
  localparam int unsigned DEF_LAYER_W = 10;
  localparam int unsigned DEF_LAYER_H = 4;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_DRAW   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sidebar_pixel_scan.sv
// Nested column/row/layer scan counters for the sidebar repaint.
module sidebar_pixel_scan
  import sidebar_pkg::*;
#(
  parameter int unsigned LAYER_W = DEF_LAYER_W,
  parameter int unsigned LAYER_H = DEF_LAYER_H,
  parameter int unsigned CW      = cnt_w(LAYER_W),
  parameter int unsigned RW      = cnt_w(LAYER_H),
  parameter int unsigned LW      = cnt_w(MAX_LAYERS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] col_nxt,
  output logic [RW-1:0] row_nxt,
  output logic [LW-1:0] layer_nxt,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          col_end, row_end, layer_end;

  // Successor position in layer/row/column order; wraps to zero after the last pixel
  always_comb begin
    col_end   = (col_q == CW'(LAYER_W - 1));
    row_end   = (row_q == RW'(LAYER_H - 1));
    layer_end = (layer_q == LW'(MAX_LAYERS - 1));
    last      = col_end && row_end && layer_end;
    col_nxt   = col_end ? '0 : col_q + CW'(1);
    row_nxt   = row_q;
    layer_nxt = layer_q;
    if (col_end) begin
      row_nxt = row_end ? '0 : row_q + RW'(1);
      if (row_end) begin
        layer_nxt = layer_end ? '0 : layer_q + LW'(1);
      end
    end
  end

  // Clear has priority over advance
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    layer_d = layer_q;
    if (clr) begin
      col_d   = '0;
      row_d   = '0;
      layer_d = '0;
    end else if (en) begin
      col_d   = col_nxt;
      row_d   = row_nxt;
      layer_d = layer_nxt;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      layer_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      layer_q <= layer_d;
    end
  end

endmodule

// File: rtl/sidebar_drawer.sv
// Repaints the cake-layer sidebar one pixel per cycle on request or layer-count change.
module sidebar_drawer
  import sidebar_pkg::*;
#(
  parameter logic [7:0]  X0      = DEF_X0,
  parameter logic [6:0]  Y_BASE  = DEF_Y_BASE,
  parameter int unsigned LAYER_W = DEF_LAYER_W,
  parameter int unsigned LAYER_H = DEF_LAYER_H
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [STACK_W-1:0] cake_stack,
  input  logic [COUNT_W-1:0] layer_count,
  input  logic               redraw_req,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [COLOUR_W-1:0] colour,
  output logic               plot,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = cnt_w(LAYER_W);
  localparam int unsigned RW = cnt_w(LAYER_H);
  localparam int unsigned LW = cnt_w(MAX_LAYERS);

  logic [1:0]          state_q, state_d;
  logic                pending_q, pending_d;
  logic [COUNT_W-1:0]  prev_cnt_q, prev_cnt_d;
  logic [STACK_W-1:0]  snap_stack_q, snap_stack_d;
  logic [COUNT_W-1:0]  snap_cnt_q, snap_cnt_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                trigger_c;
  logic [COUNT_W-1:0]  cnt_clamp_c;
  logic [STACK_W-1:0]  src_stack_c;
  logic [COUNT_W-1:0]  src_cnt_c;
  logic [CW-1:0]       pix_col_c, col_nxt;
  logic [RW-1:0]       pix_row_c, row_nxt;
  logic [LW-1:0]       pix_layer_c, layer_nxt;
  logic [7:0]          pix_x_c;
  logic [6:0]          pix_y_c;
  logic [COLOUR_W-1:0] pix_colour_c;
  logic                scan_clr, scan_en, scan_last;

  sidebar_pixel_scan #(
    .LAYER_W (LAYER_W),
    .LAYER_H (LAYER_H),
    .CW      (CW),
    .RW      (RW),
    .LW      (LW)
  ) u_scan (
    .clk       (clock),
    .rst       (resetn),
    .clr       (scan_clr),
    .en        (scan_en),
    .col_nxt   (col_nxt),
    .row_nxt   (row_nxt),
    .layer_nxt (layer_nxt),
    .last      (scan_last)
  );

  // Pixel about to be registered: LOAD emits pixel 0 from live inputs, DRAW the successor from the snapshot
  always_comb begin
    cnt_clamp_c = (layer_count > COUNT_W'(MAX_LAYERS)) ? COUNT_W'(MAX_LAYERS) : layer_count;
    trigger_c   = redraw_req || (layer_count != prev_cnt_q);
    if (state_q == ST_LOAD) begin
      pix_col_c   = '0;
      pix_row_c   = '0;
      pix_layer_c = '0;
      src_stack_c = cake_stack;
      src_cnt_c   = cnt_clamp_c;
    end else begin
      pix_col_c   = col_nxt;
      pix_row_c   = row_nxt;
      pix_layer_c = layer_nxt;
      src_stack_c = snap_stack_q;
      src_cnt_c   = snap_cnt_q;
    end
    pix_x_c = X0 + 8'(pix_col_c);
    pix_y_c = Y_BASE - 7'(32'(pix_layer_c) * LAYER_H) - 7'(pix_row_c);
    if (COUNT_W'(pix_layer_c) < src_cnt_c) begin
      pix_colour_c = src_stack_c[COLOUR_W * 32'(pix_layer_c) +: COLOUR_W];
    end else begin
      pix_colour_c = '0;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    prev_cnt_d   = layer_count;
    snap_stack_d = snap_stack_q;
    snap_cnt_d   = snap_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    colour_d     = colour_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    scan_clr     = 1'b0;
    scan_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pending_d    = pending_q || trigger_c;
        snap_stack_d = cake_stack;
        snap_cnt_d   = cnt_clamp_c;
        scan_clr     = 1'b1;
        plot_d       = 1'b1;
        x_d          = pix_x_c;
        y_d          = pix_y_c;
        colour_d     = pix_colour_c;
        state_d      = ST_DRAW;
      end
      ST_DRAW: begin
        pending_d = pending_q || trigger_c;
        if (scan_last) begin
          done_d  = 1'b1;
          state_d = ST_FINISH;
        end else begin
          scan_en  = 1'b1;
          plot_d   = 1'b1;
          x_d      = pix_x_c;
          y_d      = pix_y_c;
          colour_d = pix_colour_c;
        end
      end
      ST_FINISH: begin
        pending_d = 1'b0;
        state_d   = (pending_q || trigger_c) ? ST_LOAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      prev_cnt_q   <= layer_count;
      snap_stack_q <= '0;
      snap_cnt_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      prev_cnt_q   <= prev_cnt_d;
      snap_stack_q <= snap_stack_d;
      snap_cnt_q   <= snap_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      colour_q     <= colour_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sidebar_drawer.sv
// Scoreboard bench for sidebar_drawer at default geometry.
`timescale 1ns/1ps
module tb_sidebar_drawer;

  localparam int LW_PIX = 10;
  localparam int LH_PIX = 4;
  localparam int X_ORG  = 140;
  localparam int Y_ORG  = 110;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic [17:0] cake_stack;
  logic [2:0]  layer_count;
  logic        redraw_req;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int   n_checks = 0;
  int   n_errors = 0;
  pix_t exp_q[$];
  pix_t mon_e;
  int   cyc = 0;
  int   plot_cnt = 0;
  int   done_cnt = 0;
  int   first_plot_cyc = -1;
  int   last_done_cyc = -1;
  int   prev_done_cyc = -1;

  sidebar_drawer dut (
    .clock       (clock),
    .resetn      (resetn),
    .cake_stack  (cake_stack),
    .layer_count (layer_count),
    .redraw_req  (redraw_req),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .done        (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pop and compare each plotted pixel; track done pulses
  always @(negedge clock) begin
    if (plot === 1'b1) begin
      if (first_plot_cyc < 0) first_plot_cyc = cyc;
      plot_cnt++;
      if (exp_q.size() == 0) begin
        chk("plot_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pixel", 32'({x, y, colour}), 32'(mon_e));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
  end

  task automatic push_repaint(input logic [17:0] stk, input int cnt);
    int   eff;
    pix_t p;
    eff = (cnt > 6) ? 6 : cnt;
    for (int l = 0; l < 6; l++)
      for (int r = 0; r < LH_PIX; r++)
        for (int c = 0; c < LW_PIX; c++) begin
          p.x = 8'(X_ORG + c);
          p.y = 7'(Y_ORG - l * LH_PIX - r);
          p.c = (l < eff) ? stk[3*l +: 3] : 3'b000;
          exp_q.push_back(p);
        end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    chk("done_reached", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_plots(input int target, input int budget);
    int k;
    k = 0;
    while (plot_cnt < target && k < budget) begin
      @(posedge clock);
      k++;
    end
    #1;
    chk("plots_reached", 32'(plot_cnt >= target), 32'd1);
  endtask

  task automatic pulse_redraw();
    redraw_req = 1'b1;
    tick(1);
    redraw_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int trig, base, busy_hi, pc_hold;
    resetn      = 1'b1;
    redraw_req  = 1'b0;
    layer_count = 3'd0;
    cake_stack  = '0;
    tick(3);

    // Reset values
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_colour", 32'(colour), 32'd0);

    // Quiet release: nothing happens for 300 cycles
    resetn  = 1'b0;
    busy_hi = 0;
    repeat (300) begin
      @(negedge clock);
      if (busy !== 1'b0) busy_hi++;
    end
    chk("idle_busy", 32'(busy_hi), 32'd0);
    chk("idle_plots", 32'(plot_cnt), 32'd0);

    // One layer via layer_count 0 -> 1
    tick(1);
    cake_stack = 18'o000005;
    layer_count = 3'd1;
    trig = cyc; plot_cnt = 0; first_plot_cyc = -1; base = done_cnt;
    push_repaint(18'o000005, 1);
    tick(20);
    chk("t1_busy_mid", 32'(busy), 32'd1);
    wait_done(base + 1, 400);
    chk("t1_first_lat", 32'(first_plot_cyc - trig), 32'd2);
    chk("t1_done_lat", 32'(last_done_cyc - trig), 32'd242);
    chk("t1_plots", 32'(plot_cnt), 32'd240);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
    tick(3);
    chk("t1_done_once", 32'(done_cnt - base), 32'd1);
    chk("t1_idle", 32'(busy), 32'd0);

    // Six layers with count change and redraw in the same cycle
    cake_stack = 18'o654321;
    layer_count = 3'd6;
    redraw_req = 1'b1;
    trig = cyc; plot_cnt = 0; first_plot_cyc = -1; base = done_cnt;
    push_repaint(18'o654321, 6);
    tick(1);
    redraw_req = 1'b0;
    wait_done(base + 1, 400);
    chk("t2_first_lat", 32'(first_plot_cyc - trig), 32'd2);
    chk("t2_done_lat", 32'(last_done_cyc - trig), 32'd242);
    chk("t2_plots", 32'(plot_cnt), 32'd240);
    tick(3);
    chk("t2_done_once", 32'(done_cnt - base), 32'd1);

    // Count 7 acts as 6; stack change mid-draw must not leak in
    cake_stack = 18'o247135;
    layer_count = 3'd7;
    plot_cnt = 0; base = done_cnt;
    push_repaint(18'o247135, 7);
    wait_plots(50, 500);
    cake_stack = 18'o531642;
    wait_done(base + 1, 400);
    chk("t3_plots", 32'(plot_cnt), 32'd240);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
    tick(3);

    // Three redraws during DRAW merge into one back-to-back repaint
    plot_cnt = 0; base = done_cnt;
    push_repaint(18'o531642, 7);
    pulse_redraw();
    wait_plots(20, 100);
    push_repaint(18'o531642, 7);
    pulse_redraw();
    tick(5);
    pulse_redraw();
    tick(7);
    pulse_redraw();
    wait_done(base + 2, 800);
    chk("t4_gap", 32'(last_done_cyc - prev_done_cyc), 32'd242);
    chk("t4_plots", 32'(plot_cnt), 32'd480);
    tick(10);
    chk("t4_dones", 32'(done_cnt - base), 32'd2);
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a repaint discards it
    plot_cnt = 0; base = done_cnt;
    push_repaint(18'o531642, 7);
    pulse_redraw();
    wait_plots(100, 300);
    resetn = 1'b1;
    tick(1);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    #1;
    chk("t5_plot_drop", 32'(plot), 32'd0);
    chk("t5_busy_drop", 32'(busy), 32'd0);
    pc_hold = plot_cnt;
    tick(300);
    chk("t5_no_done", 32'(done_cnt - base), 32'd0);
    chk("t5_no_plots", 32'(plot_cnt - pc_hold), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
